md_sequencer: RTL and testbench



---
 rtl/md_sequencer.sv | 138 +++++++++++++
 tb/tb_md_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu (ops 7-10) and build the accumulate adder.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic        done
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {K_SET, K_KEEP, K_ADD, K_SUB} kind_t;

    state_t        state, state_next;
    kind_t         kind;
    logic [CW-1:0] cnt, cnt_next;
    logic [63:0]   pend, hilo_next;
    logic          commit;
    logic          is_mul, is_div, is_acc, is_signed, is_sub;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_acc    = 1'b0;
        is_signed = 1'b0;
        is_sub    = 1'b0;
        case (op_E)
            4'd1:  begin is_mul = 1'b1; is_signed = 1'b1; end
            4'd2:  is_mul = 1'b1;
            4'd3:  begin is_div = 1'b1; is_signed = 1'b1; end
            4'd4:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            4'd7:  begin is_acc = 1'b1; is_signed = 1'b1; end
            4'd8:  is_acc = 1'b1;
            4'd9:  begin is_acc = 1'b1; is_signed = 1'b1; is_sub = 1'b1; end
            4'd10: begin is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign busy     = (state == RUN);
    assign start    = (is_mul | is_div | is_acc) & ~busy;
    assign stall_md = md_D & (start | busy);

    // One 64x64 multiplier serves signed and unsigned: operands are extended per op.
    logic [63:0] mul_a, mul_b, product;
    assign mul_a   = {{32{is_signed & rs_E[31]}}, rs_E};
    assign mul_b   = {{32{is_signed & rt_E[31]}}, rt_E};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes so 0x80000000 / -1 needs no special case.
    logic        neg_a, neg_b, div_zero;
    logic [31:0] abs_a, abs_b, uq, ur, quo, rem;
    assign neg_a    = is_signed & rs_E[31];
    assign neg_b    = is_signed & rt_E[31];
    assign abs_a    = neg_a ? -rs_E : rs_E;
    assign abs_b    = neg_b ? -rt_E : rt_E;
    assign div_zero = (rt_E == 32'd0);
    assign uq       = div_zero ? 32'd0 : abs_a / abs_b;
    assign ur       = div_zero ? 32'd0 : abs_a % abs_b;
    assign quo      = (neg_a ^ neg_b) ? -uq : uq;
    assign rem      = neg_a ? -ur : ur;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_next = RUN;
                cnt_next   = is_div ? DIV_N : MULT_N;
            end
            RUN: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulating ops resolve against HI/LO as they stand at commit time.
    always_comb begin
        hilo_next = {hi, lo};
        case (kind)
            K_SET: hilo_next = pend;
`ifdef MDU_MADD_EN
            K_ADD: hilo_next = {hi, lo} + pend;
            K_SUB: hilo_next = {hi, lo} - pend;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            pend  <= '0;
            kind  <= K_KEEP;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= commit;
            if (start) begin
                pend <= is_div ? {rem, quo} : product;
                kind <= is_acc ? (is_sub ? K_SUB : K_ADD)
                               : ((is_div && div_zero) ? K_KEEP : K_SET);
            end
            if (commit)
                {hi, lo} <= hilo_next;
            else if (!busy && op_E == 4'd5)
                hi <= rs_E;
            else if (!busy && op_E == 4'd6)
                lo <= rs_E;
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: timestamp-based reference model checked every cycle plus literal pins.
module tb_md_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op_E = 4'd0;
    logic [31:0] rs_E = 32'd0, rt_E = 32'd0;
    logic        md_D = 1'b0;
    logic [31:0] hi, lo;
    logic        start, busy, stall_md, done;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .op_E(op_E), .rs_E(rs_E), .rt_E(rt_E), .md_D(md_D),
        .hi(hi), .lo(lo), .start(start), .busy(busy), .stall_md(stall_md), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an op issued in cycle T is in flight through T+lat and lands at T+lat+1.
    int          cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    logic        m_active = 1'b0, m_done = 1'b0;
    int          m_issue = 0, m_lat = 0;

    function automatic bit timed(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1:  return sa * sb;
            4'd2:  return ua * ub;
            4'd3:  begin
                if (b == 32'd0) return acc;
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            4'd4:  begin
                if (b == 32'd0) return acc;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            4'd7:  return acc + sa * sb;
            4'd8:  return acc + ua * ub;
            4'd9:  return acc - sa * sb;
            4'd10: return acc - ua * ub;
            default: return acc;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_active <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (cyc == m_issue + m_lat) begin
                    {m_hi, m_lo} <= model_result(m_op, m_a, m_b, {m_hi, m_lo});
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end else if (timed(op_E)) begin
                m_active <= 1'b1;
                m_issue  <= cyc;
                m_lat    <= (op_E == 4'd3 || op_E == 4'd4) ? DIV_N : MULT_N;
                m_op <= op_E; m_a <= rs_E; m_b <= rt_E;
            end else if (op_E == 4'd5) begin
                m_hi <= rs_E;
            end else if (op_E == 4'd6) begin
                m_lo <= rs_E;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            logic s_e;
            s_e = timed(op_E) && !m_active;
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_busy", busy, m_active);
            check("cyc_done", done, m_done);
            check("cyc_start", start, s_e);
            check("cyc_stall", stall_md, md_D && (s_e || m_active));
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    int busy_n, stall_n, done_n;
    task automatic wait_done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (stall_md) stall_n++;
            if (done) break;
            if (i == 39) check("done_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic md, input logic exp_start);
        busy_n = 0; stall_n = 0;
        #1; op_E = op; rs_E = a; rt_E = b; md_D = md;
        #1; check("issue_start", start, exp_start);
        if (stall_md) stall_n++;
        tick; op_E = 4'd0;
        if (exp_start) wait_done;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        #1; op_E = op; rs_E = v;
        tick; op_E = 4'd0;
    endtask

    task automatic pin(input string name, input logic [31:0] eh, input logic [31:0] el);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_mhi"}, m_hi, eh);
        check({name, "_mlo"}, m_lo, el);
    endtask

    initial begin
        tick; chk_en = 1'b1;
        @(negedge clk);
        pin("reset", 32'd0, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        tick; reset = 1'b0;
        tick;

        run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        pin("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        check("mult_busy_n", busy_n, MULT_N);
        check("mult_done", done, 1'b1);
        @(negedge clk);
        check("mult_done_once", done, 1'b0);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        pin("multu", 32'd1, 32'hFFFF_FFFE);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        pin("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div_busy_n", busy_n, DIV_N);

        run_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        pin("divu", 32'd1, 32'd3);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        pin("div_ovf", 32'd0, 32'h8000_0000);

        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        run_op(4'd4, 32'd1234, 32'd0, 1'b0, 1'b1);
        pin("div0", 32'h11, 32'h22);
        check("div0_busy_n", busy_n, DIV_N);
        check("div0_done", done, 1'b1);

        run_op(4'd1, 32'd3, 32'd7, 1'b1, 1'b1);
        check("stall_n_md1", stall_n, MULT_N + 1);
        check("stall_done_cycle", stall_md, 1'b0);
        run_op(4'd1, 32'd3, 32'd7, 1'b0, 1'b1);
        check("stall_n_md0", stall_n, 0);

        // Ops arriving while busy must be dropped.
        busy_n = 0; stall_n = 0;
        #1; op_E = 4'd2; rs_E = 32'd3; rt_E = 32'd4; md_D = 1'b0;
        tick; op_E = 4'd3; rs_E = 32'd100; rt_E = 32'd7;
        tick; op_E = 4'd5; rs_E = 32'hDEAD;
        tick; op_E = 4'd0;
        wait_done;
        pin("busy_ignore", 32'd0, 32'd12);

        // Reset in cycle T+3 of a divide.
        #1; op_E = 4'd4; rs_E = 32'd99; rt_E = 32'd4;
        tick; op_E = 4'd0;
        tick;
        tick; reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        tick; reset = 1'b0;
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("rst_no_done", done_n, 0);
        mt(4'd5, 32'h5);
        @(negedge clk);
        check("rst_mthi", hi, 32'h5);

        mt(4'd5, 32'd0);
        mt(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op(4'd8, 32'd1, 32'd1, 1'b1, 1'b1);
        pin("maddu", 32'd1, 32'd0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        pin("msub", 32'd1, 32'd1);
        run_op(4'd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
        pin("madd", 32'd0, 32'hFFFF_FFFB);
`else
        run_op(4'd8, 32'd1, 32'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        pin("maddu_off", 32'd0, 32'hFFFF_FFFF);
        check("maddu_off_busy", busy, 1'b0);
`endif
        md_D = 1'b0;
        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
